// File: rtl/counter_bank_arbiter_pkg.sv
// Shared types and sizes for the counter-bank arbiter slice.
// Package counter_bank_pkg: FSM state encoding and requester/select widths.
package counter_bank_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/counter_bank_arbiter_if.sv
// Requester/bank-side bus of the counter-bank arbiter.
// master = requester logic (drives req/dir), slave = arbiter.
interface counter_bank_arbiter_if;
  import counter_bank_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] dir;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               up_down;
  logic               cnt_en;
  logic               busy;

  modport master (
    output req, dir,
    input  gnt, sel, up_down, cnt_en, busy
  );

  modport slave (
    input  req, dir,
    output gnt, sel, up_down, cnt_en, busy
  );

endinterface

// File: rtl/counter_bank_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 4.
module rr_pick4
  import counter_bank_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               valid
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest slot back to ptr so the nearest active request wins.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    idx    = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_bank_arbiter.sv
// Round-robin arbiter sharing the 4-counter bank: IDLE -> SETUP -> RUN for TENURE cycles.
// Define ARB_EARLY_RELEASE_EN to end a tenure as soon as the granted req drops.
module counter_bank_arbiter
  import counter_bank_pkg::*;
#(
  parameter int TENURE   = 16,
  parameter int PTR_INIT = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  counter_bank_arbiter_if.slave  bus
);

  localparam int                TCNT_W    = $clog2(TENURE + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TENURE - 1);

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    ptr, ptr_nxt;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
  logic [NUM_REQ-1:0]  gnt_q, gnt_nxt;
  logic [SEL_W-1:0]    sel_q, sel_nxt;
  logic                up_down_q, up_down_nxt;
  logic                cnt_en_q, cnt_en_nxt;
  logic                busy_q, busy_nxt;
  logic [SEL_W-1:0]    win;
  logic                win_valid;
  logic                early_drop;
  logic                end_tenure;

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

`ifdef ARB_EARLY_RELEASE_EN
  assign early_drop = ~bus.req[sel_q];
`else
  assign early_drop = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    tcnt_nxt    = tcnt;
    gnt_nxt     = gnt_q;
    sel_nxt     = sel_q;
    up_down_nxt = up_down_q;
    cnt_en_nxt  = cnt_en_q;
    busy_nxt    = busy_q;
    end_tenure  = 1'b0;

    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt   = SETUP;
          gnt_nxt     = NUM_REQ'(1) << win;
          sel_nxt     = win;
          up_down_nxt = bus.dir[win];
          busy_nxt    = 1'b1;
        end
      end
      SETUP: begin
        if (early_drop) begin
          end_tenure = 1'b1;
        end else begin
          state_nxt  = RUN;
          cnt_en_nxt = 1'b1;
          tcnt_nxt   = '0;
        end
      end
      RUN: begin
        if (early_drop || (tcnt == TCNT_LAST)) begin
          end_tenure = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Leaving a tenure returns every output to its idle value and hands priority onward.
    if (end_tenure) begin
      state_nxt   = IDLE;
      ptr_nxt     = sel_q + SEL_W'(1);
      tcnt_nxt    = '0;
      gnt_nxt     = '0;
      sel_nxt     = '0;
      up_down_nxt = 1'b0;
      cnt_en_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= SEL_W'(PTR_INIT);
      tcnt      <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      up_down_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      tcnt      <= tcnt_nxt;
      gnt_q     <= gnt_nxt;
      sel_q     <= sel_nxt;
      up_down_q <= up_down_nxt;
      cnt_en_q  <= cnt_en_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.up_down = up_down_q;
  assign bus.cnt_en  = cnt_en_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_counter_bank_arbiter.sv
// Bench for counter_bank_arbiter: tenure-level reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours ARB_EARLY_RELEASE_EN.
module tb_counter_bank_arbiter;
  import counter_bank_pkg::*;

  localparam int TENURE   = 4;
  localparam int PTR_INIT = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  counter_bank_arbiter_if bus ();

  counter_bank_arbiter #(
    .TENURE   (TENURE),
    .PTR_INIT (PTR_INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: who owns the bank (-1 = nobody), cycles since the grant began, next priority.
  typedef struct packed {
    int   owner;
    int   age;
    int   ptr;
    logic dir;
  } model_t;

  model_t m = {32'(-1), 32'd0, 32'(PTR_INIT), 1'b0};

  function automatic model_t model_step(model_t cur, logic [3:0] r, logic [3:0] d);
    model_t n    = cur;
    bit     done = 1'b0;
    if (cur.owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx = (cur.ptr + k) % 4;
        if (n.owner < 0 && r[idx]) begin
          n.owner = idx;
          n.age   = 0;
          n.dir   = d[idx];
        end
      end
    end else begin
      done = (cur.age == TENURE);
`ifdef ARB_EARLY_RELEASE_EN
      if (!r[cur.owner]) done = 1'b1;
`endif
      if (done) begin
        n.owner = -1;
        n.age   = 0;
        n.ptr   = (cur.owner + 1) % 4;
        n.dir   = 1'b0;
      end else begin
        n.age = cur.age + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_gnt(model_t mm);
    return (mm.owner >= 0) ? (4'b0001 << mm.owner) : 4'b0000;
  endfunction
  function automatic logic [1:0] exp_sel(model_t mm);
    return (mm.owner >= 0) ? 2'(mm.owner) : 2'd0;
  endfunction
  function automatic logic exp_ud(model_t mm);
    return (mm.owner >= 0) ? mm.dir : 1'b0;
  endfunction
  function automatic logic exp_en(model_t mm);
    return (mm.owner >= 0) && (mm.age >= 1);
  endfunction
  function automatic logic exp_busy(model_t mm);
    return (mm.owner >= 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= {32'(-1), 32'd0, 32'(PTR_INIT), 1'b0};
    else        m <= model_step(m, bus.req, bus.dir);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("model_gnt",     32'(bus.gnt),     32'(exp_gnt(m)));
      check_output("model_sel",     32'(bus.sel),     32'(exp_sel(m)));
      check_output("model_up_down", 32'(bus.up_down), 32'(exp_ud(m)));
      check_output("model_cnt_en",  32'(bus.cnt_en),  32'(exp_en(m)));
      check_output("model_busy",    32'(bus.busy),    32'(exp_busy(m)));
    end
  end

  task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    #1;
    bus.req = r;
    bus.dir = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.dir = 4'b0000;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Bounded wait for the single SETUP cycle of the next grant.
  task automatic wait_setup(output logic [1:0] s, output bit ok);
    ok = 1'b0;
    s  = 2'd0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.cnt_en) begin
        ok = 1'b1;
        s  = bus.sel;
      end
    end
    check_output("setup_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] s;
    bit         ok;
    int         t_prev;
    int         en_cnt;

    bus.req = 4'b0000;
    bus.dir = 4'b0000;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check_output("reset_gnt",  32'(bus.gnt),  32'd0);
    check_output("reset_busy", 32'(bus.busy), 32'd0);

    // Single requester 2 counting up, TENURE=4.
    apply_stimulus(4'b0100, 4'b0100);
    @(negedge clk);
    check_output("c1_gnt",     32'(bus.gnt),     32'b0100);
    check_output("c1_sel",     32'(bus.sel),     32'd2);
    check_output("c1_up_down", 32'(bus.up_down), 32'd1);
    check_output("c1_cnt_en",  32'(bus.cnt_en),  32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("run_cnt_en", 32'(bus.cnt_en), 32'd1);
    end
    @(negedge clk);
    check_output("c6_gnt",  32'(bus.gnt),  32'd0);
    check_output("c6_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_output("c7_sel",  32'(bus.sel),  32'd2);
    check_output("c7_busy", 32'(bus.busy), 32'd1);

    // req=0110: grant 1 then 2; async reset during the second RUN restarts from PTR_INIT.
    do_reset();
    apply_stimulus(4'b0110, 4'b0000);
    wait_setup(s, ok);
    check_output("r6_first_sel", 32'(s), 32'd1);
    wait_setup(s, ok);
    check_output("r6_second_sel", 32'(s), 32'd2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_gnt",     32'(bus.gnt),     32'd0);
    check_output("async_sel",     32'(bus.sel),     32'd0);
    check_output("async_up_down", 32'(bus.up_down), 32'd0);
    check_output("async_cnt_en",  32'(bus.cnt_en),  32'd0);
    check_output("async_busy",    32'(bus.busy),    32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_setup(s, ok);
    check_output("r6_after_reset_sel", 32'(s), 32'd1);

    // All requesting: strict rotation, one grant every TENURE+2 cycles.
    do_reset();
    apply_stimulus(4'b1111, 4'b0101);
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_setup(s, ok);
      check_output("rr_sel", 32'(s), 32'(i % 4));
      if (i > 0) check_output("rr_period", 32'(cyc - t_prev), 32'(TENURE + 2));
      t_prev = cyc;
    end

    // Requester 1 drops req during its second RUN cycle.
    do_reset();
    apply_stimulus(4'b0010, 4'b0000);
    wait_setup(s, ok);
    check_output("drop_sel", 32'(s), 32'd1);
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.cnt_en) en_cnt++;
      if (i == 1) #1 bus.req = 4'b0000;
    end
`ifdef ARB_EARLY_RELEASE_EN
    check_output("drop_en_cycles", 32'(en_cnt), 32'd2);
`else
    check_output("drop_en_cycles", 32'(en_cnt), 32'd4);
`endif
    apply_stimulus(4'b1111, 4'b0000);
    wait_setup(s, ok);
    check_output("drop_next_sel", 32'(s), 32'd2);

    // dir[3] toggling every cycle must not disturb up_down during the tenure.
    do_reset();
    apply_stimulus(4'b1000, 4'b1000);
    wait_setup(s, ok);
    check_output("dir_sel", 32'(s), 32'd3);
    check_output("dir_setup_up_down", 32'(bus.up_down), 32'd1);
    for (int i = 0; i < 4; i++) begin
      #1 bus.dir = bus.dir ^ 4'b1000;
      @(negedge clk);
      check_output("dir_hold_up_down", 32'(bus.up_down), 32'd1);
    end

    // Randomised traffic with occasional mid-cycle reset pulses.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
      bus.dir = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
